dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, SHALL set the word address width (512-word data memory).
REQ-002 Parameter DATA_W, default 32, SHALL set the data width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 cpu_req/cpu_we  input  1/1  SHALL be the processor access request, level, and write enable.
REQ-006 cpu_addr/cpu_wdata  input  ADDR_W/DATA_W  SHALL be the processor address and store data.
REQ-007 cpu_rdata/cpu_ack/cpu_stall  output  DATA_W/1/1  SHALL be the load data, one-cycle completion pulse, and pipeline stall.
REQ-008 ext_req/ext_we/ext_addr/ext_wdata  input  1/1/ADDR_W/DATA_W  SHALL be the loader/debug port request set.
REQ-009 ext_rdata/ext_ack  output  DATA_W/1  SHALL be the loader read data and completion pulse.
REQ-010 mem_en/mem_we/mem_addr/mem_wdata  output  1/1/ADDR_W/DATA_W  SHALL drive the single-port synchronous data memory.
REQ-011 mem_rdata  input  DATA_W  SHALL be memory read data, valid one cycle after mem_en.
REQ-012 conflict_cnt  output  16  SHALL count cycles in which both requesters wait.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, RESP; IDLE->ISSUE on any req; ISSUE->RESP always; RESP->IDLE always.
REQ-014 In IDLE, the winner's we/addr/wdata and identity SHALL be latched; fields from the loser are ignored.
REQ-015 Single request SHALL be granted to that requester.
REQ-016 Simultaneous requests SHALL be granted to the port not granted last (round-robin); last_grant updates at each grant.
REQ-017 In ISSUE, mem_en=1 and mem_we/mem_addr/mem_wdata SHALL equal the latched values; in all other states mem_en=0, mem_we=0.
REQ-018 In RESP, the granted port's ack SHALL be 1 for exactly one cycle; the other ack SHALL stay 0.
REQ-019 For reads, the granted port's rdata SHALL register mem_rdata at the ISSUE->RESP edge and hold until that port's next read completes.
REQ-020 For writes, rdata SHALL be unchanged; ack still pulses.
REQ-021 Latency: req high in IDLE at cycle N -> ack high in cycle N+2; next grant no earlier than N+3.
REQ-022 A requester SHALL hold req and fields stable until ack; req still high in the cycle after ack is a new request.
REQ-023 cpu_stall SHALL equal cpu_req & ~cpu_ack (combinational).
REQ-024 Starvation bound: a waiting port SHALL be granted within one foreign transaction (<=3 cycles wait after current one ends).
REQ-025 conflict_cnt SHALL increment each cycle where cpu_req and ext_req are both high and the FSM is in IDLE, or either is high while not granted in ISSUE/RESP; saturates at 16'hFFFF.
REQ-026 Addresses SHALL pass through unchecked; wrap-around is the memory's concern.

Reset
REQ-027 On reset low: state=IDLE, last_grant=EXT (CPU wins first tie), latches, rdata outputs, acks, mem_* outputs, conflict_cnt all 0, effective immediately.
REQ-028 Reset mid-transaction SHALL abort it with no ack; a write in ISSUE may or may not reach memory.
REQ-029 Leaving reset, first grant SHALL occur on the first rising edge with reset high and a req present.

Structure
REQ-030 Shared package g9_pkg SHALL hold ADDR_W/DATA_W defaults and the FSM state encoding.
REQ-031 Round-robin choice SHALL be a sub-module rr_arbiter2 (req[1:0], last_grant -> grant one-hot).

Verification
REQ-032 CPU read addr 9'h010, mem returns 32'hDEADBEEF -> mem_en in N+1, cpu_ack and cpu_rdata=32'hDEADBEEF in N+2, cpu_stall high N..N+1.
REQ-033 EXT write addr 9'h1FF data 32'h12345678 -> mem_we=1, mem_addr=9'h1FF in N+1; ext_ack in N+2; ext_rdata unchanged.
REQ-034 Both req continuously after reset -> grant order CPU, EXT, CPU, EXT; acks every 3 cycles alternating.
REQ-035 Both req held 70000 cycles -> conflict_cnt saturates at 16'hFFFF, no wrap.
REQ-036 reset low during ISSUE of CPU read -> mem_en=0 immediately, no cpu_ack, FSM IDLE after release; re-request completes normally.

Source files
------------

// File: rtl/g9_pkg.sv
// Shared definitions for the data-memory arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default word-address and data widths
//   state_t                 : arbiter FSM state encoding
//   port_t                  : requester identity (also the round-robin history)
package g9_pkg;

    localparam int ADDR_W_DEF = 9;   // 512-word data memory
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_EXT = 1'b1
    } port_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin choice.
//   req[0] = CPU request, req[1] = EXT request
//   last_grant = port granted most recently
//   grant = one-hot winner (all zero when nothing is requested)
module rr_arbiter2
    import g9_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // On a tie the port that did not win last time goes first.
            2'b11:   grant = (last_grant == PORT_EXT) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a processor port and a loader/debug port onto one
// single-port synchronous data memory. Each access takes three cycles:
// IDLE (arbitrate + latch winner), ISSUE (drive memory), RESP (ack).
//   clk, reset           : clock, asynchronous active-low reset
//   cpu_*                : processor request/response, cpu_stall = req & ~ack
//   ext_*                : loader/debug request/response
//   mem_*                : memory command outputs, mem_rdata valid the cycle
//                          after mem_en
//   conflict_cnt         : saturating count of cycles with a waiting requester
module dmem_arbiter
    import g9_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       conflict_cnt
);

    state_t            state, state_nxt;
    port_t             last_grant;
    port_t             lat_id;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] cpu_hold, ext_hold;
    logic [1:0]        grant;
    logic              any_req;
    logic              resp_rd;
    logic              waiting;

    assign any_req = cpu_req | ext_req;

    rr_arbiter2 u_rr (
        .req        ({ext_req, cpu_req}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // A requester waits in IDLE only when it loses a tie; during a
    // transaction any request from the non-owner is waiting.
    always_comb begin
        waiting = 1'b0;
        if (state == ST_IDLE)
            waiting = cpu_req & ext_req;
        else
            waiting = (cpu_req & (lat_id != PORT_CPU)) |
                      (ext_req & (lat_id != PORT_EXT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            last_grant   <= PORT_EXT;
            lat_id       <= PORT_CPU;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            cpu_hold     <= '0;
            ext_hold     <= '0;
            conflict_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && any_req) begin
                lat_id     <= grant[1] ? PORT_EXT : PORT_CPU;
                last_grant <= grant[1] ? PORT_EXT : PORT_CPU;
                lat_we     <= grant[1] ? ext_we    : cpu_we;
                lat_addr   <= grant[1] ? ext_addr  : cpu_addr;
                lat_wdata  <= grant[1] ? ext_wdata : cpu_wdata;
            end
            if (resp_rd) begin
                if (lat_id == PORT_CPU) cpu_hold <= mem_rdata;
                else                    ext_hold <= mem_rdata;
            end
            if (waiting && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    assign mem_en    = (state == ST_ISSUE);
    assign mem_we    = mem_en & lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    assign cpu_ack   = (state == ST_RESP) & (lat_id == PORT_CPU);
    assign ext_ack   = (state == ST_RESP) & (lat_id == PORT_EXT);
    assign cpu_stall = cpu_req & ~cpu_ack;

    // The memory's data only arrives in RESP, so it is forwarded straight
    // to the owner's rdata alongside the ack and captured for holding on
    // the way back to IDLE. Externally rdata changes at the ISSUE->RESP
    // edge and then holds until that port's next read.
    assign resp_rd   = (state == ST_RESP) & ~lat_we;
    assign cpu_rdata = (resp_rd && lat_id == PORT_CPU) ? mem_rdata : cpu_hold;
    assign ext_rdata = (resp_rd && lat_id == PORT_EXT) ? mem_rdata : ext_hold;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk, reset;
    logic          cpu_req, cpu_we, ext_req, ext_we;
    logic [AW-1:0] cpu_addr, ext_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, ext_wdata, cpu_rdata, ext_rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          cpu_ack, cpu_stall, ext_ack, mem_en, mem_we;
    logic [15:0]   conflict_cnt;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_ack(ext_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        return (i == 16) ? 32'hDEADBEEF : (i * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Environment: single-port synchronous memory.
    logic [DW-1:0] ram [512];
    initial for (int i = 0; i < 512; i++) ram[i] <= init_val(i);
    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: each granted access occupies three
    // cycles (phase 0 arbitrate, 1 memory command, 2 response).
    int            phase, e_cnt, cpu_age, ext_age;
    bit            owner, last, m_we, age_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, e_cpu_rd, e_ext_rd;
    logic [DW-1:0] mmem [512];
    initial for (int i = 0; i < 512; i++) mmem[i] = init_val(i);

    always @(negedge clk) begin : model
        bit e_cack, e_eack, wt, win;
        if (!reset) begin
            phase = 0; last = 1; e_cnt = 0;
            e_cpu_rd = '0; e_ext_rd = '0; cpu_age = 0; ext_age = 0;
        end
        e_cack = (phase == 2) && !owner;
        e_eack = (phase == 2) && owner;
        chk("mem_en",    mem_en,    phase == 1);
        chk("mem_we",    mem_we,    (phase == 1) && m_we);
        if (phase == 1) begin
            chk("mem_addr",  mem_addr,  m_addr);
            chk("mem_wdata", mem_wdata, m_wd);
        end
        chk("cpu_ack",   cpu_ack,   e_cack);
        chk("ext_ack",   ext_ack,   e_eack);
        chk("cpu_stall", cpu_stall, cpu_req && !e_cack);
        chk("cpu_rdata", cpu_rdata, e_cpu_rd);
        chk("ext_rdata", ext_rdata, e_ext_rd);
        chk("conflict_cnt", conflict_cnt, e_cnt);
        if (age_en) begin
            if (e_cack) begin chk("cpu_wait_bound", cpu_age <= 5, 1); cpu_age = 0; end
            else if (cpu_req) cpu_age++; else cpu_age = 0;
            if (e_eack) begin chk("ext_wait_bound", ext_age <= 5, 1); ext_age = 0; end
            else if (ext_req) ext_age++; else ext_age = 0;
        end
        if (reset) begin
            wt = (phase == 0) ? (cpu_req && ext_req)
                              : ((cpu_req && owner) || (ext_req && !owner));
            if (wt && e_cnt < 65535) e_cnt++;
            case (phase)
                0: if (cpu_req || ext_req) begin
                       win    = (cpu_req && ext_req) ? !last : ext_req;
                       owner  = win; last = win;
                       m_we   = win ? ext_we    : cpu_we;
                       m_addr = win ? ext_addr  : cpu_addr;
                       m_wd   = win ? ext_wdata : cpu_wdata;
                       phase  = 1;
                   end
                1: begin
                       if (m_we)       mmem[m_addr] = m_wd;
                       else if (owner) e_ext_rd = mmem[m_addr];
                       else            e_cpu_rd = mmem[m_addr];
                       phase = 2;
                   end
                default: phase = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    bit ca, ea;

    initial begin
        reset = 1'b0; age_en = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_cnt",       conflict_cnt, 0);
        tick(); reset = 1'b1;

        // CPU read of 0x010 returning DEADBEEF.
        tick(); cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        @(negedge clk); chk("r32_stall_n",  cpu_stall, 1); chk("r32_en_n", mem_en, 0);
        @(negedge clk); chk("r32_en_n1",    mem_en, 1);    chk("r32_addr", mem_addr, 9'h010);
                        chk("r32_stall_n1", cpu_stall, 1);
        @(negedge clk); chk("r32_ack",      cpu_ack, 1);   chk("r32_rdata", cpu_rdata, 32'hDEADBEEF);
                        chk("r32_stall_n2", cpu_stall, 0);
        tick(); cpu_req = 0;
        repeat (2) tick();

        // EXT write 0x1FF <- 12345678.
        ext_req = 1; ext_we = 1; ext_addr = 9'h1FF; ext_wdata = 32'h12345678;
        @(negedge clk);
        @(negedge clk); chk("w33_we", mem_we, 1); chk("w33_addr", mem_addr, 9'h1FF);
                        chk("w33_wd", mem_wdata, 32'h12345678);
        @(negedge clk); chk("w33_ack", ext_ack, 1); chk("w33_cack", cpu_ack, 0);
                        chk("w33_rdata", ext_rdata, 0);
        tick(); ext_req = 0; ext_we = 0;
        repeat (2) tick();

        // Both requesting from reset release: CPU, EXT, CPU, EXT.
        reset = 0; tick();
        reset = 1; cpu_req = 1; cpu_addr = 9'h005; ext_req = 1; ext_addr = 9'h006;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            chk($sformatf("rr_cpu_ack%0d", j), cpu_ack, (j == 2 || j == 8));
            chk($sformatf("rr_ext_ack%0d", j), ext_ack, (j == 5 || j == 11));
            if (j == 11) chk("rr_cnt", conflict_cnt, 11);
        end
        tick(); cpu_req = 0; ext_req = 0;
        repeat (3) tick();

        // Random protocol-compliant traffic.
        age_en = 1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); ca = cpu_ack; ea = ext_ack;
            tick();
            if (!cpu_req || ca) begin
                cpu_req = ($urandom_range(0, 3) != 0);
                cpu_we = $urandom_range(0, 1); cpu_wdata = $urandom;
                cpu_addr = $urandom_range(0, 1) ? 9'($urandom_range(0, 7)) : 9'($urandom_range(0, 255));
            end
            if (!ext_req || ea) begin
                ext_req = ($urandom_range(0, 2) != 0);
                ext_we = $urandom_range(0, 1); ext_wdata = $urandom;
                ext_addr = $urandom_range(0, 1) ? 9'($urandom_range(0, 7)) : 9'($urandom_range(0, 255));
            end
        end
        cpu_req = 0; ext_req = 0;
        repeat (4) tick();
        age_en = 0;

        // Reset during ISSUE of a CPU read, then re-request.
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h120;
        tick(); #1 reset = 0; #1;
        chk("r36_en",  mem_en, 0);
        chk("r36_we",  mem_we, 0);
        chk("r36_ack", cpu_ack, 0);
        @(negedge clk); chk("r36_ack_rst", cpu_ack, 0);
        tick(); reset = 1;
        @(negedge clk); chk("r36_idle_en", mem_en, 0);
        @(negedge clk); chk("r36_re_en",   mem_en, 1);
        @(negedge clk); chk("r36_re_ack",  cpu_ack, 1);
                        chk("r36_re_data", cpu_rdata, init_val(9'h120));
        tick(); cpu_req = 0;
        repeat (2) tick();

        // Long contention: counter must saturate, never wrap.
        cpu_req = 1; cpu_addr = 9'h011; ext_req = 1; ext_we = 0; ext_addr = 9'h012;
        repeat (70000) @(posedge clk);
        @(negedge clk); chk("sat_cnt", conflict_cnt, 16'hFFFF);
        tick(); cpu_req = 0; ext_req = 0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
